// File: rtl/dmem_pkg.sv
// Shared types and elaboration helpers for the data-memory responder.
// Holds the FSM encoding and the lane/offset arithmetic used by every file.
package dmem_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Ceiling log2; used to turn the lane count into the byte-offset width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int lanes_of(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port byte-enabled RAM with a registered read; latency 1 cycle.
// No backpressure: one access per cycle, read data is forced to 0 on non-read cycles.
module dmem_bram
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = lanes_of(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Zeroing idle read data here keeps the response bus clean without an output mux.
  always_ff @(posedge clock) begin
    if (reset || !re) rdata <= '0;
    else              rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stores into a byte-enabled array, loads return after READ_LATENCY cycles.
// Backpressure: memory_ready low during post-reset clear only; responses cannot be stalled.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter bit INIT_ZERO    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memory_read,
  input  logic              memory_write,
  input  logic [XLEN/8-1:0] memory_byte_en,
  input  logic [XLEN-1:0]   memory_address_out,
  input  logic [XLEN-1:0]   memory_data_out,
  output logic [XLEN-1:0]   memory_data_in,
  output logic [XLEN-1:0]   memory_address_in,
  output logic              memory_valid,
  output logic              memory_ready,
  output logic              protocol_error
);

  localparam int LANES = lanes_of(XLEN);
  localparam int S     = clog2(LANES);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("dmem_responder: XLEN must be 32 or 64");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("dmem_responder: READ_LATENCY must be 1..8");
  end

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] addr;
  } meta_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  load_acc;
  logic                  store_acc;
  logic                  ram_we;
  logic [LANES-1:0]      ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [XLEN-1:0]       ram_wdata;
  logic [XLEN-1:0]       ram_rdata;
  meta_t                 meta_q [READ_LATENCY];

  assign word_idx  = memory_address_out[ADDR_WIDTH+S-1:S];
  assign accept    = memory_ready && !reset && (memory_read || memory_write);
  assign store_acc = accept && memory_write;
  // A combined read+write performs only the write.
  assign load_acc  = accept && memory_read && !memory_write;

  always_comb begin
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = word_idx;
    ram_wdata = memory_data_out;
    if (state == ST_INIT) begin
      ram_we    = !reset;
      ram_be    = '1;
      ram_addr  = clr_ptr;
      ram_wdata = '0;
    end else begin
      ram_we    = store_acc;
      ram_be    = memory_byte_en;
    end
  end

  dmem_bram #(
    .DATA_W (XLEN),
    .ADDR_W (ADDR_WIDTH)
  ) u_bram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (load_acc),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT_ZERO ? ST_INIT : ST_RUN;
      clr_ptr        <= '0;
      memory_ready   <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state        <= ST_RUN;
            memory_ready <= 1'b1;
          end
        end
        ST_RUN: memory_ready <= 1'b1;
      endcase
      if (accept && memory_read && memory_write) protocol_error <= 1'b1;
    end
  end

  // Valid/address travel alongside the RAM read; stage 0 lines up with the RAM output.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) meta_q[i] <= '0;
    end else begin
      meta_q[0].vld  <= load_acc;
      meta_q[0].addr <= load_acc ? memory_address_out : '0;
      for (int i = 1; i < READ_LATENCY; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  assign memory_valid      = meta_q[READ_LATENCY-1].vld;
  assign memory_address_in = meta_q[READ_LATENCY-1].addr;

  if (READ_LATENCY == 1) begin : g_direct
    assign memory_data_in = ram_rdata;
  end else begin : g_pipe
    logic [XLEN-1:0] data_q [READ_LATENCY-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) data_q[i] <= '0;
      end else begin
        data_q[0] <= ram_rdata;
        for (int i = 1; i < READ_LATENCY - 1; i++) data_q[i] <= data_q[i-1];
      end
    end

    assign memory_data_in = data_q[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard and latency tracking.
module tb_dmem_responder;

  localparam int XLEN = 64;
  localparam int AW   = 4;
  localparam int RL   = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            memory_read;
  logic            memory_write;
  logic [7:0]      memory_byte_en;
  logic [XLEN-1:0] memory_address_out;
  logic [XLEN-1:0] memory_data_out;
  logic [XLEN-1:0] memory_data_in;
  logic [XLEN-1:0] memory_address_in;
  logic            memory_valid;
  logic            memory_ready;
  logic            protocol_error;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;

  dmem_responder #(
    .XLEN         (XLEN),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .INIT_ZERO    (1'b1)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .memory_read        (memory_read),
    .memory_write       (memory_write),
    .memory_byte_en     (memory_byte_en),
    .memory_address_out (memory_address_out),
    .memory_data_out    (memory_data_out),
    .memory_data_in     (memory_data_in),
    .memory_address_in  (memory_address_in),
    .memory_valid       (memory_valid),
    .memory_ready       (memory_ready),
    .protocol_error     (protocol_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every valid, checks idle zeros otherwise.
  always @(negedge clock) begin
    if (mon_en) begin
      if (memory_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 64'(memory_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_data", memory_data_in, mon_e.data);
          check("resp_addr", memory_address_in, mon_e.addr);
          check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        check("idle_data", memory_data_in, 64'd0);
        check("idle_addr", memory_address_in, 64'd0);
      end
    end
  end

  task automatic issue_load(input logic [63:0] a, input logic [63:0] d);
    exp_t e;
    memory_read        = 1'b1;
    memory_write       = 1'b0;
    memory_address_out = a;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + RL;
    sb.push_back(e);
    @(negedge clock);
    memory_read        = 1'b0;
    memory_address_out = '0;
  endtask

  task automatic issue_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    memory_write       = 1'b1;
    memory_read        = 1'b0;
    memory_address_out = a;
    memory_data_out    = d;
    memory_byte_en     = be;
    @(negedge clock);
    memory_write       = 1'b0;
    memory_byte_en     = '0;
    memory_data_out    = '0;
    memory_address_out = '0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Called on the negedge after the last reset edge: 16 not-ready cycles, then ready.
  task automatic init_window();
    for (int k = 0; k < 16; k++) begin
      check("ready_low_init", 64'(memory_ready), 64'd0);
      @(negedge clock);
    end
    check("ready_high", 64'(memory_ready), 64'd1);
  endtask

  initial begin
    reset              = 1'b1;
    memory_read        = 1'b0;
    memory_write       = 1'b0;
    memory_byte_en     = '0;
    memory_address_out = '0;
    memory_data_out    = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 64'(memory_valid), 64'd0);
    check("rst_ready", 64'(memory_ready), 64'd0);
    check("rst_data", memory_data_in, 64'd0);
    check("rst_addr", memory_address_in, 64'd0);
    check("rst_perr", 64'(protocol_error), 64'd0);
    mon_en = 1'b1;
    reset  = 1'b0;
    init_window();

    issue_load(64'h40, 64'h0);
    drain();

    issue_store(64'h18, 64'h1122334455667788, 8'hFF);
    issue_load(64'h18, 64'h1122334455667788);
    drain();

    issue_store(64'h18, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    issue_load(64'h18, 64'h11223344AAAAAAAA);
    issue_load(64'h1B, 64'h11223344AAAAAAAA);
    drain();

    issue_store(64'h00, 64'h0123456789ABCDEF, 8'hFF);
    issue_store(64'h08, 64'hFEDCBA9876543210, 8'hFF);
    issue_store(64'h10, 64'hDEADBEEFCAFEF00D, 8'hFF);
    issue_store(64'h08, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    issue_load(64'h00, 64'h0123456789ABCDEF);
    issue_load(64'h08, 64'hFEDCBA9876543210);
    issue_load(64'h10, 64'hDEADBEEFCAFEF00D);
    issue_load(64'h80, 64'h0123456789ABCDEF);
    drain();

    memory_read        = 1'b1;
    memory_write       = 1'b1;
    memory_address_out = 64'h20;
    memory_data_out    = 64'h5;
    memory_byte_en     = 8'hFF;
    @(negedge clock);
    memory_read        = 1'b0;
    memory_write       = 1'b0;
    memory_byte_en     = '0;
    memory_address_out = '0;
    memory_data_out    = '0;
    check("perr_set", 64'(protocol_error), 64'd1);
    repeat (10) @(negedge clock);
    check("perr_sticky", 64'(protocol_error), 64'd1);
    issue_load(64'h20, 64'h5);
    drain();

    memory_read        = 1'b1;
    memory_address_out = 64'h18;
    @(negedge clock);
    memory_read        = 1'b0;
    memory_address_out = '0;
    reset              = 1'b1;
    @(negedge clock);
    check("midrst_valid", 64'(memory_valid), 64'd0);
    check("midrst_perr", 64'(protocol_error), 64'd0);
    reset = 1'b0;
    init_window();
    repeat (3) @(negedge clock);
    issue_load(64'h18, 64'h0);
    issue_load(64'h40, 64'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
